// File: rtl/water_pkg.sv
// Shared constants and state encoding for the drum water valve controller.
package water_pkg;

  localparam int LEVEL_W            = 10;
  localparam int DEF_TOLERANCE      = 10;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_MAX_RETRIES    = 2;
  localparam int DEF_MAX_SAFE_LEVEL = 900;
  // flow_error is ignored for the entry cycle of a phase and the one after it
  localparam int MASK_CYCLES        = 2;

  localparam logic MODE_FILL  = 1'b1;
  localparam logic MODE_DRAIN = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_FILL,
    ST_DRAIN,
    ST_SETTLE,
    ST_DONE,
    ST_FAULT
  } valve_state_t;

endpackage

// File: rtl/water_valve_controller_if.sv
// Sequencer/sensor/monitor side signals of the valve controller; slave = controller.
interface water_valve_controller_if #(
  parameter int LEVEL_W = water_pkg::LEVEL_W
);
  logic               start;
  logic [LEVEL_W-1:0] target_level;
  logic [LEVEL_W-1:0] water_level_sensor;
  logic               flow_error;
  logic               fill_valve;
  logic               drain_pump;
  logic               mode;
  logic               monitor_reset;
  logic               busy;
  logic               done;
  logic               fault;

  modport master (
    output start, target_level, water_level_sensor, flow_error,
    input  fill_valve, drain_pump, mode, monitor_reset, busy, done, fault
  );

  modport slave (
    input  start, target_level, water_level_sensor, flow_error,
    output fill_valve, drain_pump, mode, monitor_reset, busy, done, fault
  );
endinterface

// File: rtl/wm_cycle_timer.sv
// Loadable down-counter that saturates at zero; expired while the count is zero.
module wm_cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/water_valve_controller.sv
// Drives fill valve / drain pump toward a latched target level with bounded retry and sticky fault.
// Define OVERFLOW_GUARD_EN to add the MAX_SAFE_LEVEL overflow cut-off and target clamp.
module water_valve_controller #(
  parameter int LEVEL_W        = water_pkg::LEVEL_W,
  parameter int TOLERANCE      = water_pkg::DEF_TOLERANCE,
  parameter int SETTLE_CYCLES  = water_pkg::DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES    = water_pkg::DEF_MAX_RETRIES,
  parameter int MAX_SAFE_LEVEL = water_pkg::DEF_MAX_SAFE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  water_valve_controller_if.slave vif
);
  import water_pkg::*;

`ifdef OVERFLOW_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  localparam int TMAX = (SETTLE_CYCLES > MASK_CYCLES) ? SETTLE_CYCLES : MASK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [LEVEL_W:0]   TOL_E       = (LEVEL_W+1)'(TOLERANCE);
  localparam logic [LEVEL_W-1:0] SAFE_L      = LEVEL_W'(MAX_SAFE_LEVEL);
  localparam logic [TW-1:0]      MASK_LOAD   = TW'(MASK_CYCLES);
  localparam logic [TW-1:0]      SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  valve_state_t       state_q, state_d;
  logic [LEVEL_W-1:0] tgt_q, tgt_d, tgt_in;
  logic [RW-1:0]      retry_q, retry_d;
  logic               mode_q, mode_d;
  logic               fill_q, fill_d, drain_q, drain_d, mon_rst_q, mon_rst_d;
  logic               busy_q, busy_d, done_q, done_d, fault_q, fault_d;

  logic [LEVEL_W:0]   lvl_e, tgt_e;
  logic               need_fill, need_drain, over_level, retry_ok, take_retry;
  logic               timer_load, timer_exp, err_live;
  logic [TW-1:0]      timer_val;

  // One extra bit so that level+TOLERANCE and tgt+TOLERANCE never wrap
  assign lvl_e      = {1'b0, vif.water_level_sensor};
  assign tgt_e      = {1'b0, tgt_q};
  assign need_fill  = (lvl_e + TOL_E) < tgt_e;
  assign need_drain = lvl_e > (tgt_e + TOL_E);
  assign over_level = GUARD_EN && (vif.water_level_sensor > SAFE_L);
  assign tgt_in     = (GUARD_EN && (vif.target_level > SAFE_L)) ? SAFE_L : vif.target_level;
  assign retry_ok   = retry_q < RW'(MAX_RETRIES);
  assign err_live   = vif.flow_error && timer_exp;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    retry_d    = retry_q;
    mode_d     = mode_q;
    take_retry = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (vif.start) begin
          tgt_d   = tgt_in;
          retry_d = '0;
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (need_fill) begin
          state_d = ST_FILL;
          mode_d  = MODE_FILL;
        end else if (need_drain) begin
          state_d = ST_DRAIN;
          mode_d  = MODE_DRAIN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FILL: begin
        if (over_level)          state_d = ST_FAULT;
        else if (err_live)       take_retry = 1'b1;
        else if (lvl_e >= tgt_e) state_d = ST_SETTLE;
      end
      ST_DRAIN: begin
        if (err_live)            take_retry = 1'b1;
        else if (lvl_e <= tgt_e) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_exp) begin
          if (!need_fill && !need_drain) state_d = ST_DONE;
          else                           take_retry = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (take_retry) begin
      if (retry_ok) begin
        retry_d = retry_q + RW'(1);
        state_d = ST_DECIDE;
      end else begin
        state_d = ST_FAULT;
      end
    end
  end

  // Outputs are registered from the state being entered, so they line up with state_q
  always_comb begin
    fill_d     = (state_d == ST_FILL) && !over_level;
    drain_d    = (state_d == ST_DRAIN);
    mon_rst_d  = (state_d != state_q) && ((state_d == ST_FILL) || (state_d == ST_DRAIN));
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    done_d     = (state_d == ST_DONE);
    fault_d    = (state_d == ST_FAULT);
    timer_load = (state_d != state_q) &&
                 ((state_d == ST_FILL) || (state_d == ST_DRAIN) || (state_d == ST_SETTLE));
    timer_val  = (state_d == ST_SETTLE) ? SETTLE_LOAD : MASK_LOAD;
  end

  wm_cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tgt_q     <= '0;
      retry_q   <= '0;
      mode_q    <= MODE_FILL;
      fill_q    <= 1'b0;
      drain_q   <= 1'b0;
      mon_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      retry_q   <= retry_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
      drain_q   <= drain_d;
      mon_rst_q <= mon_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign vif.fill_valve    = fill_q;
  assign vif.drain_pump    = drain_q;
  assign vif.mode          = mode_q;
  assign vif.monitor_reset = mon_rst_q;
  assign vif.busy          = busy_q;
  assign vif.done          = done_q;
  assign vif.fault         = fault_q;
endmodule

// File: tb/tb_water_valve_controller.sv
// Directed bench: a simple drum plant reacts to the valves; outcomes are scoreboarded per start.
module tb_water_valve_controller;
  import water_pkg::*;

  localparam int LW = 10;

  typedef struct {
    int outcome;   // 1 = done, 2 = fault
    int level;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   level, step;
  int   n_chk = 0, n_fail = 0;
  int   fill_cyc, drain_cyc, mr_cnt, settle_cyc, viol, mode_bad, lat, inj_cyc;
  bit   prev_f, prev_d, seen;
  exp_t sb[$];

  always #5 clk = ~clk;

  water_valve_controller_if #(.LEVEL_W(LW)) vif ();
  assign vif.water_level_sensor = LW'(level);

  water_valve_controller #(
    .LEVEL_W(LW), .TOLERANCE(10), .SETTLE_CYCLES(4), .MAX_RETRIES(2), .MAX_SAFE_LEVEL(900)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {vif.fill_valve, vif.drain_pump, vif.mode, vif.monitor_reset,
            vif.busy, vif.done, vif.fault};
  endfunction

  task automatic do_start(input int tgt, input int exp_out, input int exp_lvl, input bit push);
    exp_t e;
    @(negedge clk);
    vif.start        = 1'b1;
    vif.target_level = LW'(tgt);
    if (push) begin
      e.outcome = exp_out;
      e.level   = exp_lvl;
      sb.push_back(e);
    end
    @(negedge clk);
    vif.start = 1'b0;
  endtask

  // Runs the plant until done/fault, then pops the scoreboard entry for this start
  task automatic run_to_end(input string tag, input int budget);
    int   cyc = 0;
    int   outcome = 0;
    exp_t e;
    fill_cyc = 0; drain_cyc = 0; mr_cnt = 0; settle_cyc = 0; viol = 0; mode_bad = 0;
    seen = 0; lat = 0;
    while (outcome == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (vif.fill_valve && vif.drain_pump) viol++;
      if ((prev_f && vif.drain_pump) || (prev_d && vif.fill_valve)) viol++;
      prev_f = vif.fill_valve;
      prev_d = vif.drain_pump;
      if (vif.monitor_reset) mr_cnt++;
      if (vif.fill_valve) begin
        fill_cyc++; seen = 1;
        if (vif.mode !== MODE_FILL) mode_bad++;
      end
      if (vif.drain_pump) begin
        drain_cyc++; seen = 1;
        if (vif.mode !== MODE_DRAIN) mode_bad++;
      end
      if (seen && vif.busy && !vif.fill_valve && !vif.drain_pump && !vif.done) settle_cyc++;
      if (vif.done === 1'b1)       outcome = 1;
      else if (vif.fault === 1'b1) outcome = 2;
      else begin
        if (vif.fill_valve)  level = (level + step > 1023) ? 1023 : level + step;
        if (vif.drain_pump)  level = (level > step) ? level - step : 0;
      end
      if (cyc == inj_cyc) begin
        vif.start = 1'b1;
        vif.target_level = '0;
      end else begin
        vif.start = 1'b0;
      end
    end
    lat = cyc;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.outcome = -1; e.level = -1; end
    chk({tag, "_outcome"}, outcome, e.outcome);
    chk({tag, "_level"}, level, e.level);
    chk({tag, "_overlap"}, viol, 0);
    chk({tag, "_mode"}, mode_bad, 0);
  endtask

  initial begin
    reset = 1'b1; level = 0; step = 0; inj_cyc = -1; prev_f = 0; prev_d = 0;
    vif.start = 1'b0; vif.target_level = '0; vif.flow_error = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 7'b0010000);
    reset = 1'b0;

    // Fill 50 -> 150 at +20/cycle
    level = 50; step = 20;
    do_start(150, 1, 150, 1);
    run_to_end("fill", 200);
    chk("fill_cycles", fill_cyc, 5);
    chk("fill_drain_cycles", drain_cyc, 0);
    chk("fill_mon_reset", mr_cnt, 1);
    chk("fill_settle", settle_cyc, 4);
    @(negedge clk);
    chk("fill_done_pulse", {vif.done, vif.busy}, 2'b00);

    // Drain 200 -> 60 at -20/cycle
    level = 200;
    do_start(60, 1, 60, 1);
    run_to_end("drain", 200);
    chk("drain_cycles", drain_cyc, 7);
    chk("drain_fill_cycles", fill_cyc, 0);
    chk("drain_settle", settle_cyc, 4);

    // Already in band: straight to DONE
    level = 105;
    do_start(100, 1, 105, 1);
    run_to_end("inband", 50);
    chk("inband_valves", fill_cyc + drain_cyc + mr_cnt, 0);
    chk("inband_latency", lat, 1);

    // tgt = 0 boundary
    level = 10;
    do_start(0, 1, 10, 1);
    run_to_end("tgt0", 50);
    chk("tgt0_valves", fill_cyc + drain_cyc, 0);

    // Persistent flow error: 3 attempts of 3 valve cycles each, then fault
    level = 50; step = 0; vif.flow_error = 1'b1;
    do_start(150, 2, 50, 1);
    run_to_end("flowerr", 200);
    chk("flowerr_fill_cycles", fill_cyc, 9);
    chk("flowerr_mon_reset", mr_cnt, 3);
    repeat (3) @(negedge clk);
    chk("fault_sticky", {vif.fill_valve, vif.drain_pump, vif.busy, vif.fault}, 4'b0001);
    vif.flow_error = 1'b0; step = 20;
    do_start(150, 1, 150, 1);
    chk("restart_clears_fault", {vif.fault, vif.busy}, 2'b01);
    run_to_end("restart", 200);

    // Overshoot: settle out of band twice, third time faults
    level = 50; step = 40;
    do_start(150, 2, 170, 1);
    run_to_end("overshoot", 300);
    chk("overshoot_fill", fill_cyc, 4);
    chk("overshoot_drain", drain_cyc, 1);
    chk("overshoot_mon_reset", mr_cnt, 3);

    // Start while busy is ignored (would otherwise retarget to 0)
    level = 50; step = 20; inj_cyc = 2;
    do_start(150, 1, 150, 1);
    run_to_end("busy_start", 200);
    chk("busy_start_fill", fill_cyc, 5);
    inj_cyc = -1;

    // Reset during FILL
    level = 50; step = 0;
    do_start(150, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("midreset_filling", vif.fill_valve, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outs", outs(), 7'b0010000);
    reset = 1'b0;
    prev_f = 0; prev_d = 0;

`ifndef OVERFLOW_GUARD_EN
    // tgt = 1023 fills until the sensor saturates
    level = 1000; step = 20;
    do_start(1023, 1, 1023, 1);
    run_to_end("tgt1023", 200);
    chk("tgt1023_fill", fill_cyc, 2);
`else
    // Target clamped to 900: 905 is already in band
    level = 905; step = 20;
    do_start(1000, 1, 905, 1);
    run_to_end("clamp", 50);
    chk("clamp_valves", fill_cyc + drain_cyc, 0);
    // Level passes 900 during FILL: immediate fault
    level = 841;
    do_start(1000, 2, 901, 1);
    run_to_end("overflow", 200);
    chk("overflow_fill", fill_cyc, 3);
    chk("overflow_valve_off", vif.fill_valve, 1'b0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
